// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one uart_tx serialiser
//            among NUM_REQ byte producers. Grants one byte per frame through
//            a valid/ready handshake, pulses uart_tx_start, holds the byte on
//            uart_tx_input and times the frame locally (uart_tx has no done).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int CLKS_PER_BIT = 10416,
   parameter int FRAME_CLKS   = 10*CLKS_PER_BIT+2,
   parameter int IDX_W        = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 uart_tx_start,
   output logic [7:0]           uart_tx_input,
   output logic                 busy,
   output logic [IDX_W-1:0]     grant_idx
);

   // Last count value of the SEND phase; SEND lasts exactly FRAME_CLKS cycles.
   localparam logic [31:0] LAST_CNT = 32'(FRAME_CLKS - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [31:0]          frame_cnt;
   logic [31:0]          frame_cnt_nxt;
   logic [NUM_REQ-1:0]   ready_nxt;
   logic                 start_nxt;
   logic [7:0]           data_nxt;
   logic                 busy_nxt;
   logic [IDX_W-1:0]     grant_nxt;

   int                   cand;
   logic [IDX_W-1:0]     cand_idx;
   logic [IDX_W-1:0]     winner;
   logic                 win_found;
   logic [7:0]           win_data;

   // Rotating-priority search: the most recent winner is examined last.
   always_comb begin
      cand      = 0;
      cand_idx  = '0;
      winner    = grant_idx;
      win_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand     = (int'(grant_idx) + k) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!win_found && req_valid[cand_idx]) begin
            winner    = cand_idx;
            win_found = 1'b1;
         end
      end
   end

   // Byte lane of the winning requester.
   always_comb begin
      win_data = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == IDX_W'(i)) begin
            win_data = req_data[8*i +: 8];
         end
      end
   end

   // Next-state and registered-output values; pulses default low.
   always_comb begin
      state_nxt     = state;
      frame_cnt_nxt = frame_cnt;
      ready_nxt     = '0;
      start_nxt     = 1'b0;
      data_nxt      = uart_tx_input;
      busy_nxt      = busy;
      grant_nxt     = grant_idx;
      case (state)
         IDLE: begin
            busy_nxt = 1'b0;
            if (enable && win_found) begin
               ready_nxt     = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
               start_nxt     = 1'b1;
               data_nxt      = win_data;
               grant_nxt     = winner;
               busy_nxt      = 1'b1;
               frame_cnt_nxt = '0;
               state_nxt     = SEND;
            end
         end
         SEND: begin
            // Requests and enable are ignored here; the frame always completes.
            if (frame_cnt == LAST_CNT) begin
               state_nxt     = IDLE;
               busy_nxt      = 1'b0;
               frame_cnt_nxt = '0;
            end else begin
               frame_cnt_nxt = frame_cnt + 32'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any frame in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         frame_cnt     <= '0;
         req_ready     <= '0;
         uart_tx_start <= 1'b0;
         uart_tx_input <= 8'h00;
         busy          <= 1'b0;
         grant_idx     <= IDX_W'(NUM_REQ - 1);
      end else begin
         state         <= state_nxt;
         frame_cnt     <= frame_cnt_nxt;
         req_ready     <= ready_nxt;
         uart_tx_start <= start_nxt;
         uart_tx_input <= data_nxt;
         busy          <= busy_nxt;
         grant_idx     <= grant_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter: directed scenarios plus
//            randomized requesters, compared each cycle to a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

   localparam int NUM_REQ      = 4;
   localparam int CLKS_PER_BIT = 4;
   localparam int FRAME_CLKS   = 10*CLKS_PER_BIT+2;
   localparam int IDX_W        = 2;

   logic                 clk       = 1'b0;
   logic                 reset     = 1'b0;
   logic                 enable    = 1'b0;
   logic [NUM_REQ-1:0]   req_valid = '0;
   logic [NUM_REQ*8-1:0] req_data  = '0;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 uart_tx_start;
   logic [7:0]           uart_tx_input;
   logic                 busy;
   logic [IDX_W-1:0]     grant_idx;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: remaining SEND cycles, last winner, held byte, pulse values.
   int                 m_left;
   int                 m_last;
   logic [7:0]         m_data;
   logic [NUM_REQ-1:0] m_ready;
   logic               m_start;

   int cyc            = 0;
   int last_start_cyc = -1;
   bit track_spacing  = 1'b0;
   int seen[$];

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ      (NUM_REQ),
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .FRAME_CLKS   (FRAME_CLKS),
      .IDX_W        (IDX_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .uart_tx_start (uart_tx_start),
      .uart_tx_input (uart_tx_input),
      .busy          (busy),
      .grant_idx     (grant_idx)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_left         = 0;
      m_last         = NUM_REQ - 1;
      m_data         = 8'h00;
      m_ready        = '0;
      m_start        = 1'b0;
      last_start_cyc = -1;
   endtask

   // One clock edge of the frame-level behaviour.
   task automatic model_edge();
      m_ready = '0;
      m_start = 1'b0;
      if (!reset) begin
         model_reset();
         return;
      end
      if (m_left > 0) begin
         m_left--;
         return;
      end
      if (enable && (req_valid != '0)) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (m_last + k) % NUM_REQ;
            if (req_valid[c]) begin
               m_last = c;
               break;
            end
         end
         m_ready[m_last] = 1'b1;
         m_start         = 1'b1;
         m_data          = req_data[m_last*8 +: 8];
         m_left          = FRAME_CLKS;
      end
   endtask

   task automatic compare_outputs();
      check("req_ready",     32'(req_ready),     32'(m_ready));
      check("uart_tx_start", 32'(uart_tx_start), 32'(m_start));
      check("uart_tx_input", 32'(uart_tx_input), 32'(m_data));
      check("busy",          32'(busy),          32'(m_left > 0));
      check("grant_idx",     32'(grant_idx),     32'(m_last));
   endtask

   // Advance one clock: update model at the edge, compare at the falling edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      cyc++;
      if (m_start) begin
         if (track_spacing && last_start_cyc >= 0)
            check("start_spacing", 32'(cyc - last_start_cyc), 32'(FRAME_CLKS + 1));
         last_start_cyc = cyc;
      end
      @(negedge clk);
      compare_outputs();
      if (uart_tx_start) seen.push_back(int'(grant_idx));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Requesters that saw their accept pulse withdraw the request.
   task automatic retire();
      for (int i = 0; i < NUM_REQ; i++)
         if (req_ready[i]) req_valid[i] = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      steps(2);
      reset = 1'b1;
   endtask

   initial begin
      int exp_order[5];
      int busy_cnt;
      int start_cnt;
      int stable_cnt;

      model_reset();
      repeat (2) @(negedge clk);
      compare_outputs();                      // reset state
      reset = 1'b1;

      // 1: single requester 0 with A5
      req_data[7:0] = 8'hA5;
      req_valid     = 4'b0001;
      enable        = 1'b1;
      step();
      check("t1_ready", 32'(req_ready), 32'h1);
      check("t1_start", 32'(uart_tx_start), 32'h1);
      check("t1_byte",  32'(uart_tx_input), 32'hA5);
      busy_cnt = int'(busy);
      retire();
      for (int i = 0; i < 44; i++) begin
         step();
         busy_cnt += int'(busy);
      end
      check("t1_busy_len", 32'(busy_cnt), 32'(FRAME_CLKS));

      // 2: all four held -> rotation 0,1,2,3,0, 43-cycle spacing
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) req_data[i*8 +: 8] = 8'(8'h10 + i);
      req_valid     = 4'b1111;
      track_spacing = 1'b1;
      seen.delete();
      steps(1 + 4*(FRAME_CLKS+1) + 2);
      track_spacing = 1'b0;
      exp_order = '{0, 1, 2, 3, 0};
      check("t2_ngrants", 32'(seen.size()), 32'd5);
      for (int i = 0; i < 5 && i < seen.size(); i++) check("t2_order", 32'(seen[i]), 32'(exp_order[i]));
      req_valid = '0;
      steps(FRAME_CLKS + 2);

      // 3: wrap-around from grant_idx 3 with requesters 0 and 3
      do_reset();
      req_valid = 4'b1001;
      seen.delete();
      steps(1 + 2*(FRAME_CLKS+1) + 2);
      exp_order = '{0, 3, 0, 0, 0};
      check("t3_ngrants", 32'(seen.size()), 32'd3);
      for (int i = 0; i < 3 && i < seen.size(); i++) check("t3_order", 32'(seen[i]), 32'(exp_order[i]));
      req_valid = '0;
      steps(FRAME_CLKS + 2);

      // 4: enable gating, then enable dropped mid-frame
      enable    = 1'b0;
      req_valid = 4'b0010;
      start_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         start_cnt += int'(uart_tx_start) + int'(req_ready != '0);
      end
      check("t4_no_grant", 32'(start_cnt), 32'd0);
      enable = 1'b1;
      step();
      check("t4_grant1", 32'(req_ready), 32'h2);
      retire();
      steps(10);
      enable    = 1'b0;
      req_valid = 4'b0010;
      start_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         start_cnt += int'(uart_tx_start);
      end
      check("t4_no_regrant", 32'(start_cnt), 32'd0);
      check("t4_idle", 32'(busy), 32'd0);
      req_valid = '0;
      enable    = 1'b1;

      // 5: requester withdraws right after grant; byte must stay put
      do_reset();
      req_data[23:16] = 8'h3C;
      req_valid       = 4'b0100;
      step();
      step();
      req_valid       = '0;
      req_data[23:16] = 8'hFF;
      stable_cnt = 0;
      for (int i = 0; i < FRAME_CLKS; i++) begin
         step();
         stable_cnt += int'(uart_tx_input == 8'h3C);
      end
      check("t5_stable", 32'(stable_cnt), 32'(FRAME_CLKS));

      // 6: asynchronous reset 20 cycles into SEND
      req_data[7:0] = 8'h5A;
      req_valid     = 4'b0001;
      step();
      retire();
      steps(20);
      #2 reset = 1'b0;
      #1;
      check("t6_ready", 32'(req_ready),     32'h0);
      check("t6_start", 32'(uart_tx_start), 32'h0);
      check("t6_byte",  32'(uart_tx_input), 32'h00);
      check("t6_busy",  32'(busy),          32'h0);
      check("t6_gidx",  32'(grant_idx),     32'h3);
      model_reset();
      steps(2);
      reset     = 1'b1;
      req_valid = 4'b1111;
      step();
      check("t6_first0", 32'(grant_idx), 32'h0);
      req_valid = '0;
      steps(FRAME_CLKS + 2);

      // Randomized requesters and enable
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         step();
         enable = ($urandom_range(0, 9) != 0);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               req_valid[i] = 1'b0;
            end else if (req_valid[i] && $urandom_range(0, 199) == 0) begin
               req_valid[i] = 1'b0;
            end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
               req_valid[i]       = 1'b1;
               req_data[i*8 +: 8] = 8'($urandom);
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
